regfile64: RTL and testbench

Architectural integer register file for the LEGv8 datapath, directly upstream of the ALU. It holds X0–X30 and hardwires X31 (XZR) to zero. Two combinational read ports drive the ALU's busA and, through the ALUSrc mux, its busB. One synchronous write port takes the writeback value (ALU result or memory load) on the rising clock edge, and a write-first bypass lets a same-cycle read of the register being written return the new value.

---
 rtl/regfile64.sv | 76 +++++++
 tb/tb_regfile64.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile64.sv
// regfile64 - LEGv8 architectural integer register file (X0..X30, XZR).
//
// Holds the writable integer registers and hardwires ZERO_REG (XZR) to zero.
// It has two combinational read ports and one synchronous write port. A
// write-first bypass lets a read of the register being written in the same
// cycle return the incoming writeback value.
//
// Ports:
//   Clk    in   1       clock; all state changes on the rising edge
//   Reset  in   1       synchronous active-high clear of all registers
//   RA     in   ADDR_W  read address, port A
//   RB     in   ADDR_W  read address, port B
//   RW     in   ADDR_W  write address
//   BusW   in   DATA_W  write data (writeback value)
//   RegWr  in   1       write enable
//   BusA   out  DATA_W  read data, port A (ALU busA)
//   BusB   out  DATA_W  read data, port B (ALUSrc mux / store data)

module regfile64 #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] BusW,
    input  logic              RegWr,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB
);

    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // A write is only real when not in reset and not aimed at XZR.
    logic wr_en;
    assign wr_en = RegWr && !Reset && (RW != ZERO_ADDR);

    // The XZR entry is cleared by reset and never written, but the read mux
    // below forces zero for it anyway, so its contents never matter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[RW] <= BusW;
        end
    end

    // Each port resolves on its own: XZR first, then bypass, then storage.
    // The bypass is off during reset, so only stored values show then.
    always_comb begin
        BusA = mem[RA];
        if (RA == ZERO_ADDR) begin
            BusA = '0;
        end else if (wr_en && (RW == RA)) begin
            BusA = BusW;
        end
    end

    always_comb begin
        BusB = mem[RB];
        if (RB == ZERO_ADDR) begin
            BusB = '0;
        end else if (wr_en && (RW == RB)) begin
            BusB = BusW;
        end
    end

endmodule

// File: tb/tb_regfile64.sv
module tb_regfile64;

    logic        Clk;
    logic        Reset;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [63:0] BusA;
    logic [63:0] BusB;

    int n_cmp;
    int n_err;

    // Reference contents of the architectural registers.
    logic [63:0] ref_regs [32];

    regfile64 dut (
        .Clk   (Clk),
        .Reset (Reset),
        .RA    (RA),
        .RB    (RB),
        .RW    (RW),
        .BusW  (BusW),
        .RegWr (RegWr),
        .BusA  (BusA),
        .BusB  (BusB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected read value for the current inputs.
    function automatic logic [63:0] exp_rd(input logic [4:0] addr);
        if (addr == 5'd31)
            return 64'd0;
        if (RegWr && !Reset && RW == addr)
            return BusW;
        return ref_regs[addr];
    endfunction

    // Apply the current inputs to the model, then advance one edge.
    task automatic tick();
        if (Reset) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
        end else if (RegWr && RW != 5'd31) begin
            ref_regs[RW] = BusW;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        Reset = 1'b0; RegWr = 1'b1; RW = a; BusW = d;
        tick();
        RegWr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++)
            do_write(5'($urandom_range(0, 30)), {$urandom, $urandom});
        Reset = 1'b1; RegWr = 1'b1; RW = 5'd5; BusW = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        Reset = 1'b0; RegWr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(31 - i);
            #1;
            n_cmp++;
            if (BusA !== 64'd0) begin
                n_err++;
                $display("FAIL reset_clear_A addr=%0d got=%h want=0", i, BusA);
            end
            n_cmp++;
            if (BusB !== 64'd0) begin
                n_err++;
                $display("FAIL reset_clear_B addr=%0d got=%h want=0", 31 - i, BusB);
            end
        end
    endtask

    task automatic test_write_read_all();
        logic [63:0] base;
        base = 64'h0123_4567_89AB_0000;
        for (int i = 0; i < 31; i++)
            do_write(5'(i), base + 64'(i));
        for (int i = 0; i < 31; i++) begin
            RA = 5'(i); RB = 5'(30 - i);
            #1;
            n_cmp++;
            if (BusA !== base + 64'(i)) begin
                n_err++;
                $display("FAIL wr_all_A addr=%0d got=%h want=%h", i, BusA, base + 64'(i));
            end
            n_cmp++;
            if (BusB !== base + 64'(30 - i)) begin
                n_err++;
                $display("FAIL wr_all_B addr=%0d got=%h want=%h", 30 - i, BusB, base + 64'(30 - i));
            end
        end
        RA = 5'd31; RB = 5'd31;
        #1;
        n_cmp++;
        if (BusA !== 64'd0 || BusB !== 64'd0) begin
            n_err++;
            $display("FAIL wr_all_xzr got A=%h B=%h want 0", BusA, BusB);
        end
    endtask

    task automatic test_xzr();
        RegWr = 1'b1; RW = 5'd31; BusW = 64'hDEAD_BEEF_DEAD_BEEF; RA = 5'd31; RB = 5'd31;
        #1;
        n_cmp++;
        if (BusA !== 64'd0 || BusB !== 64'd0) begin
            n_err++;
            $display("FAIL xzr_same_cycle got A=%h B=%h want 0", BusA, BusB);
        end
        tick();
        RegWr = 1'b0;
        #1;
        n_cmp++;
        if (BusA !== 64'd0) begin
            n_err++;
            $display("FAIL xzr_after_edge got=%h want=0", BusA);
        end
        for (int i = 0; i < 31; i++) begin
            RA = 5'(i);
            #1;
            n_cmp++;
            if (BusA !== 64'h0123_4567_89AB_0000 + 64'(i)) begin
                n_err++;
                $display("FAIL xzr_no_side_effect addr=%0d got=%h want=%h", i, BusA,
                         64'h0123_4567_89AB_0000 + 64'(i));
            end
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 64'h10);
        RegWr = 1'b0; RW = 5'd7; BusW = 64'h20; RA = 5'd7; RB = 5'd7;
        #1;
        n_cmp++;
        if (BusA !== 64'h10) begin
            n_err++;
            $display("FAIL bypass_disabled got=%h want=10", BusA);
        end
        RegWr = 1'b1;
        #1;
        n_cmp++;
        if (BusA !== 64'h20 || BusB !== 64'h20) begin
            n_err++;
            $display("FAIL bypass_before_edge got A=%h B=%h want 20", BusA, BusB);
        end
        tick();
        RegWr = 1'b0;
        #1;
        n_cmp++;
        if (BusA !== 64'h20 || BusB !== 64'h20) begin
            n_err++;
            $display("FAIL bypass_after_edge got A=%h B=%h want 20", BusA, BusB);
        end
    endtask

    task automatic test_independent();
        do_write(5'd3, 64'h1);
        do_write(5'd4, 64'h2);
        RA = 5'd3; RB = 5'd4; RW = 5'd4; RegWr = 1'b1; BusW = 64'h99;
        #1;
        n_cmp++;
        if (BusA !== 64'h1 || BusB !== 64'h99) begin
            n_err++;
            $display("FAIL independent got A=%h B=%h want A=1 B=99", BusA, BusB);
        end
        tick();
        RegWr = 1'b0;
    endtask

    task automatic test_reset_vs_bypass();
        do_write(5'd9, 64'h77);
        Reset = 1'b1; RegWr = 1'b1; RW = 5'd9; RA = 5'd9; RB = 5'd9; BusW = 64'h55;
        #1;
        n_cmp++;
        if (BusA !== 64'h77) begin
            n_err++;
            $display("FAIL rst_bypass_before got=%h want=77", BusA);
        end
        tick();
        #1;
        n_cmp++;
        if (BusA !== 64'd0) begin
            n_err++;
            $display("FAIL rst_bypass_after got=%h want=0", BusA);
        end
        Reset = 1'b0; BusW = 64'hAB;
        tick();
        RegWr = 1'b0;
        #1;
        n_cmp++;
        if (BusA !== 64'hAB) begin
            n_err++;
            $display("FAIL write_after_reset got=%h want=ab", BusA);
        end
    endtask

    task automatic test_back_to_back();
        do_write(5'd12, 64'h1111);
        do_write(5'd12, 64'h2222);
        RA = 5'd12;
        #1;
        n_cmp++;
        if (BusA !== 64'h2222) begin
            n_err++;
            $display("FAIL back_to_back got=%h want=2222", BusA);
        end
    endtask

    task automatic test_random();
        logic [63:0] ea, eb;
        for (int c = 0; c < 400; c++) begin
            Reset = ($urandom_range(0, 24) == 0);
            RegWr = $urandom_range(0, 1) == 1;
            RW    = 5'($urandom_range(0, 31));
            RA    = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
            RB    = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
            BusW  = {$urandom, $urandom};
            #1;
            ea = exp_rd(RA);
            eb = exp_rd(RB);
            n_cmp++;
            if (BusA !== ea) begin
                n_err++;
                $display("FAIL random_A cyc=%0d ra=%0d got=%h want=%h", c, RA, BusA, ea);
            end
            n_cmp++;
            if (BusB !== eb) begin
                n_err++;
                $display("FAIL random_B cyc=%0d rb=%0d got=%h want=%h", c, RB, BusB, eb);
            end
            tick();
        end
        Reset = 1'b0; RegWr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i);
            #1;
            ea = exp_rd(RA);
            n_cmp++;
            if (BusA !== ea) begin
                n_err++;
                $display("FAIL random_final addr=%0d got=%h want=%h", i, BusA, ea);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
        Reset = 1'b1; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;
        tick();
        Reset = 1'b0;
        test_reset();
        test_write_read_all();
        test_xzr();
        test_bypass();
        test_independent();
        test_reset_vs_bypass();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
